// File: rtl/regression_nxn_solver_pkg.sv
// Shared types and fixed-point helpers
// for the NxN Gauss-Jordan solver.
package regression_nxn_solver_pkg;

  localparam int WIDTH = 32;
  localparam int QFRAC = 16;

  localparam logic signed [WIDTH-1:0] Q_ONE =
    32'sh0001_0000;
  localparam logic signed [WIDTH-1:0] MAXV =
    {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MINV =
    {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_PIVOT,
    S_SWAP,
    S_NORM,
    S_ELIM,
    S_OUT,
    S_SING,
    S_DONE
  } state_t;

  typedef struct packed {
    logic                    ovf;
    logic signed [WIDTH-1:0] val;
  } sat_t;

  // a - b with one guard bit, clamped.
  function automatic sat_t sat_sub(
    input logic signed [WIDTH-1:0] a,
    input logic signed [WIDTH-1:0] b
  );
    logic signed [WIDTH:0] d;
    sat_t r;
    d = {a[WIDTH-1], a} - {b[WIDTH-1], b};
    r.ovf = d[WIDTH] ^ d[WIDTH-1];
    if (!r.ovf)  r.val = d[WIDTH-1:0];
    else if (d[WIDTH]) r.val = MINV;
    else r.val = MAXV;
    return r;
  endfunction

  // |a|, with |MINV| clamped to MAXV.
  function automatic logic [WIDTH-1:0] abs_sat(
    input logic signed [WIDTH-1:0] a
  );
    if (a == MINV) return MAXV;
    if (a[WIDTH-1]) return -a;
    return a;
  endfunction

endpackage

// File: rtl/regression_nxn_solver_pivot_sel.sv
// Combinational argmax of |col[r]| over
// rows k..N-1; ties keep the lowest row.
module regression_nxn_solver_pivot_sel
  import regression_nxn_solver_pkg::*;
#(
  parameter int N  = 3,
  parameter int RW = $clog2(N)
) (
  input  logic [N*WIDTH-1:0] col_flat,
  input  logic [RW-1:0]      k,
  output logic [RW-1:0]      p,
  output logic [WIDTH-1:0]   mag
);

  logic [WIDTH-1:0] v;

  // Strict '>' keeps the first maximum.
  always_comb begin
    p   = k;
    mag = '0;
    v   = '0;
    for (int r = 0; r < N; r++) begin
      v = abs_sat(col_flat[r*WIDTH +: WIDTH]);
      if (r >= int'(k) && v > mag) begin
        mag = v;
        p   = RW'(r);
      end
    end
  end

endmodule

// File: rtl/regression_nxn_solver.sv
// NxN fixed-point Gauss-Jordan solver with
// partial pivoting, one mul and one div unit.
module regression_nxn_solver
  import regression_nxn_solver_pkg::*;
#(
  parameter int N           = 3,
  parameter int MUL_LATENCY = 1,
  parameter int DIV_LATENCY = 1,
  parameter logic signed [WIDTH-1:0] PIVOT_EPS =
    32'sd16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [N*N*WIDTH-1:0]   A_flat,
  input  logic [N*WIDTH-1:0]     B_flat,
  output logic                   busy,
  output logic                   done,
  output logic                   singular,
  output logic                   overflow,
  output logic [N*WIDTH-1:0]     beta
);

  localparam int RW = $clog2(N);
  localparam int CW = $clog2(N+1);
  localparam int DW = 2*WIDTH;

  typedef logic signed [WIDTH-1:0] word_t;

  state_t state_q, state_d;
  logic [RW-1:0] k_q, k_d, i_q, i_d;
  logic [RW-1:0] p_q, p_d;
  logic [CW-1:0] j_q, j_d;
  word_t aug_q [N][N+1];
  word_t aug_d [N][N+1];
  word_t beta_q [N];
  word_t beta_d [N];
  logic busy_q, busy_d, done_q, done_d;
  logic sing_q, sing_d, ovf_q, ovf_d;
  logic op_busy_q, op_busy_d;
  logic [7:0] op_cnt_q, op_cnt_d;
  word_t op_a_q, op_a_d, op_b_q, op_b_d;

  logic [CW-1:0] kc;
  logic [N*WIDTH-1:0] col_flat;
  logic [RW-1:0] piv_p;
  logic [WIDTH-1:0] piv_mag;
  logic signed [DW-1:0] prod_w;
  logic signed [DW-1:0] num_w, den_w;
  word_t mul_res, div_res;
  sat_t sat_res;
  logic op_done;
  logic [RW-1:0] first_i, nxt_i;
  logic last_row;
  int ni;

  assign kc = CW'(k_q);

  // Column k of the working matrix for pivoting.
  always_comb begin
    col_flat = '0;
    for (int r = 0; r < N; r++)
      col_flat[r*WIDTH +: WIDTH] = aug_q[r][kc];
  end

  regression_nxn_solver_pivot_sel #(
    .N (N)
  ) u_piv (
    .col_flat (col_flat),
    .k        (k_q),
    .p        (piv_p),
    .mag      (piv_mag)
  );

  // Shared mul/div datapath on registered operands.
  always_comb begin
    prod_w  = op_a_q * op_b_q;
    mul_res = WIDTH'(prod_w >>> QFRAC);
    num_w   = DW'(op_a_q) <<< QFRAC;
    den_w   = DW'(op_b_q);
    div_res = (den_w == '0) ? '0
            : WIDTH'(num_w / den_w);
    sat_res = sat_sub(aug_q[i_q][j_q], mul_res);
  end

  // Row sequencing for elimination (skip row k).
  always_comb begin
    first_i = (k_q == '0) ? RW'(1) : '0;
    ni = int'(i_q) + 1;
    if (ni == int'(k_q)) ni = ni + 1;
    last_row = (ni >= N);
    nxt_i = RW'(ni);
  end

  assign op_done = op_busy_q &&
                   (op_cnt_q == 8'd1);

  // Next-state and datapath updates.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    i_d       = i_q;
    j_d       = j_q;
    p_d       = p_q;
    aug_d     = aug_q;
    beta_d    = beta_q;
    sing_d    = sing_q;
    ovf_d     = ovf_q;
    op_busy_d = op_busy_q;
    op_cnt_d  = op_cnt_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    unique case (state_q)
      S_IDLE: if (start) begin
        for (int r = 0; r < N; r++) begin
          for (int c = 0; c < N; c++)
            aug_d[r][c] =
              A_flat[(r*N+c)*WIDTH +: WIDTH];
          aug_d[r][N] = B_flat[r*WIDTH +: WIDTH];
        end
        sing_d  = 1'b0;
        ovf_d   = 1'b0;
        k_d     = '0;
        state_d = S_LOAD;
      end
      S_LOAD: state_d = S_PIVOT;
      S_PIVOT: begin
        if (piv_mag < $unsigned(PIVOT_EPS))
          state_d = S_SING;
        else begin
          p_d     = piv_p;
          state_d = S_SWAP;
        end
      end
      S_SWAP: begin
        aug_d[k_q] = aug_q[p_q];
        aug_d[p_q] = aug_q[k_q];
        j_d        = CW'(N);
        state_d    = S_NORM;
      end
      S_NORM: begin
        if (!op_busy_q) begin
          op_busy_d = 1'b1;
          op_cnt_d  = 8'(DIV_LATENCY);
          op_a_d    = aug_q[k_q][j_q];
          op_b_d    = aug_q[k_q][kc];
        end else if (op_done) begin
          op_busy_d = 1'b0;
          aug_d[k_q][j_q] = div_res;
          if (j_q == kc) begin
            i_d     = first_i;
            j_d     = CW'(N);
            state_d = S_ELIM;
          end else
            j_d = j_q - CW'(1);
        end else
          op_cnt_d = op_cnt_q - 8'd1;
      end
      S_ELIM: begin
        if (!op_busy_q) begin
          op_busy_d = 1'b1;
          op_cnt_d  = 8'(MUL_LATENCY);
          op_a_d    = aug_q[i_q][kc];
          op_b_d    = aug_q[k_q][j_q];
        end else if (op_done) begin
          op_busy_d = 1'b0;
          aug_d[i_q][j_q] = sat_res.val;
          if (sat_res.ovf) ovf_d = 1'b1;
          if (j_q != kc)
            j_d = j_q - CW'(1);
          else if (!last_row) begin
            i_d = nxt_i;
            j_d = CW'(N);
          end else if (k_q == RW'(N-1))
            state_d = S_OUT;
          else begin
            k_d     = k_q + RW'(1);
            state_d = S_PIVOT;
          end
        end else
          op_cnt_d = op_cnt_q - 8'd1;
      end
      S_OUT: begin
        for (int r = 0; r < N; r++)
          beta_d[r] = aug_q[r][N];
        state_d = S_DONE;
      end
      S_SING: begin
        sing_d = 1'b1;
        for (int r = 0; r < N; r++)
          beta_d[r] = '0;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // Single register bank for FSM and datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      i_q       <= '0;
      j_q       <= '0;
      p_q       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sing_q    <= 1'b0;
      ovf_q     <= 1'b0;
      op_busy_q <= 1'b0;
      op_cnt_q  <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      for (int r = 0; r < N; r++) begin
        beta_q[r] <= '0;
        for (int c = 0; c <= N; c++)
          aug_q[r][c] <= '0;
      end
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      i_q       <= i_d;
      j_q       <= j_d;
      p_q       <= p_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sing_q    <= sing_d;
      ovf_q     <= ovf_d;
      op_busy_q <= op_busy_d;
      op_cnt_q  <= op_cnt_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      beta_q    <= beta_d;
      aug_q     <= aug_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign singular = sing_q;
  assign overflow = ovf_q;

  // Flatten the solution vector.
  always_comb begin
    beta = '0;
    for (int r = 0; r < N; r++)
      beta[r*WIDTH +: WIDTH] = beta_q[r];
  end

endmodule

// File: tb/tb_regression_nxn_solver.sv
// Directed bench: N=3 and N=2 solver
// instances sharing clock and reset.
module tb_regression_nxn_solver;

  localparam logic [31:0] ONE = 32'h0001_0000;
  localparam int TMO = 500;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        start3 = 1'b0;
  logic [287:0] a3 = '0;
  logic [95:0]  b3 = '0;
  logic        busy3, done3, sing3, ovf3;
  logic [95:0] beta3;

  logic        start2 = 1'b0;
  logic [127:0] a2 = '0;
  logic [63:0]  b2 = '0;
  logic        busy2, done2, sing2, ovf2;
  logic [63:0] beta2;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  regression_nxn_solver #(.N(3)) u_dut3 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start3),
    .A_flat   (a3),
    .B_flat   (b3),
    .busy     (busy3),
    .done     (done3),
    .singular (sing3),
    .overflow (ovf3),
    .beta     (beta3)
  );

  regression_nxn_solver #(.N(2)) u_dut2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start2),
    .A_flat   (a2),
    .B_flat   (b2),
    .busy     (busy2),
    .done     (done2),
    .singular (sing2),
    .overflow (ovf2),
    .beta     (beta2)
  );

  task automatic set_a3(input int r, input int c,
                        input logic [31:0] v);
    a3[(r*3+c)*32 +: 32] = v;
  endtask

  task automatic load3(
    input logic [31:0] r0c0, r0c1, r0c2,
    input logic [31:0] r1c0, r1c1, r1c2,
    input logic [31:0] r2c0, r2c1, r2c2,
    input logic [31:0] y0, y1, y2);
    set_a3(0, 0, r0c0); set_a3(0, 1, r0c1);
    set_a3(0, 2, r0c2); set_a3(1, 0, r1c0);
    set_a3(1, 1, r1c1); set_a3(1, 2, r1c2);
    set_a3(2, 0, r2c0); set_a3(2, 1, r2c1);
    set_a3(2, 2, r2c2);
    b3 = {y2, y1, y0};
  endtask

  // Pulse start, wait for done (bounded).
  task automatic solve3(input string nm,
                        output int cyc);
    @(negedge clk); start3 = 1'b1;
    @(negedge clk); start3 = 1'b0;
    nvec++;
    if (busy3 !== 1'b1) begin
      nerr++;
      $display("FAIL %s busy_after_start got %b want 1",
               nm, busy3);
    end
    cyc = 0;
    while (done3 !== 1'b1 && cyc < TMO) begin
      @(negedge clk);
      cyc++;
    end
    nvec++;
    if (cyc >= TMO) begin
      nerr++;
      $display("FAIL %s timeout got no done want done",
               nm);
    end
  endtask

  task automatic chk3(input string nm,
                      input logic [95:0] eb,
                      input logic es, input logic eo);
    nvec++;
    if (beta3 !== eb) begin
      nerr++;
      $display("FAIL %s beta got %h want %h",
               nm, beta3, eb);
    end
    nvec++;
    if ({sing3, ovf3} !== {es, eo}) begin
      nerr++;
      $display("FAIL %s sing/ovf got %b%b want %b%b",
               nm, sing3, ovf3, es, eo);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    nvec++;
    if ({busy3, done3, sing3, ovf3} !== 4'b0) begin
      nerr++;
      $display("FAIL reset flags3 got %b want 0000",
               {busy3, done3, sing3, ovf3});
    end
    nvec++;
    if (beta3 !== '0 || beta2 !== '0) begin
      nerr++;
      $display("FAIL reset beta got %h %h want 0",
               beta3, beta2);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_identity(input string nm);
    int cyc;
    int pulses;
    load3(ONE, 0, 0, 0, ONE, 0, 0, 0, ONE,
          ONE, 32'h0002_0000, 32'h0003_0000);
    solve3(nm, cyc);
    chk3(nm, {32'h0003_0000, 32'h0002_0000,
              32'h0001_0000}, 1'b0, 1'b0);
    pulses = 0;
    @(negedge clk);
    nvec++;
    if (busy3 !== 1'b0) begin
      nerr++;
      $display("FAIL %s busy_after_done got %b want 0",
               nm, busy3);
    end
    repeat (4) begin
      if (done3 === 1'b1) pulses++;
      @(negedge clk);
    end
    nvec++;
    if (pulses != 0) begin
      nerr++;
      $display("FAIL %s extra_done got %0d want 0",
               nm, pulses);
    end
  endtask

  task automatic test_pivot_swap();
    int cyc;
    load3(0, ONE, 0, ONE, 0, 0, 0, 0, 32'h0002_0000,
          32'h0003_0000, 32'h0004_0000,
          32'h0008_0000);
    solve3("pivot_swap", cyc);
    chk3("pivot_swap", {32'h0004_0000,
         32'h0003_0000, 32'h0004_0000},
         1'b0, 1'b0);
    @(negedge clk);
  endtask

  task automatic test_singular();
    int cyc;
    load3(ONE, 32'h0002_0000, 32'h0003_0000,
          32'h0002_0000, 32'h0004_0000,
          32'h0006_0000,
          ONE, 0, ONE,
          ONE, ONE, ONE);
    solve3("singular", cyc);
    chk3("singular", 96'h0, 1'b1, 1'b0);
    @(negedge clk);
  endtask

  task automatic test_saturation();
    int cyc;
    load3(ONE, 0, 0, ONE, ONE, 0, 0, 0, ONE,
          32'h8000_0000, 32'h7FFF_0000, ONE);
    solve3("saturation", cyc);
    chk3("saturation", {ONE, 32'h7FFF_FFFF,
         32'h8000_0000}, 1'b0, 1'b1);
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int pulses;
    load3(0, ONE, 0, ONE, 0, 0, 0, 0, 32'h0002_0000,
          32'h0003_0000, 32'h0004_0000,
          32'h0008_0000);
    @(negedge clk); start3 = 1'b1;
    @(negedge clk); start3 = 1'b0;
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    nvec++;
    if ({busy3, done3, sing3, ovf3} !== 4'b0 ||
        beta3 !== '0) begin
      nerr++;
      $display("FAIL reset_mid state got %b %h want 0",
               {busy3, done3, sing3, ovf3}, beta3);
    end
    rst_n = 1'b1;
    pulses = 0;
    repeat (120) begin
      @(negedge clk);
      if (done3 === 1'b1 || busy3 === 1'b1) pulses++;
    end
    nvec++;
    if (pulses != 0) begin
      nerr++;
      $display("FAIL reset_mid activity got %0d want 0",
               pulses);
    end
    test_identity("after_reset");
  endtask

  task automatic test_n2_busy_start();
    int cyc;
    a2 = {32'h0004_0000, 32'h0, 32'h0,
          32'h0002_0000};
    b2 = {32'h0008_0000, 32'h0004_0000};
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    @(negedge clk);
    a2 = {ONE, 32'h0, 32'h0, ONE};
    b2 = {ONE, ONE};
    start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    nvec++;
    if (busy2 !== 1'b1) begin
      nerr++;
      $display("FAIL n2 busy got %b want 1", busy2);
    end
    cyc = 0;
    while (done2 !== 1'b1 && cyc < TMO) begin
      @(negedge clk);
      cyc++;
    end
    nvec++;
    if (cyc >= TMO) begin
      nerr++;
      $display("FAIL n2 timeout got no done want done");
    end
    nvec++;
    if (beta2 !== {32'h0002_0000, 32'h0002_0000} ||
        {sing2, ovf2} !== 2'b00) begin
      nerr++;
      $display("FAIL n2 beta got %h %b%b want %h 00",
               beta2, sing2, ovf2,
               {32'h0002_0000, 32'h0002_0000});
    end
    @(negedge clk);
    nvec++;
    if ({busy2, done2} !== 2'b00) begin
      nerr++;
      $display("FAIL n2 idle got %b want 00",
               {busy2, done2});
    end
  endtask

  initial begin
    test_reset();
    test_identity("identity");
    test_pivot_swap();
    test_singular();
    test_saturation();
    test_reset_mid();
    test_n2_busy_start();
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
